val_matrix: RTL and testbench
=============================

// Module: val_matrix
// PURPOSE
//  Registered DIM x COLS matrix of W-bit values with a per-cell valid bitmap.
//  Single-cell write port, one registered row-read port, a per-row sum of valid cells, and global status.
//  Small scratch/lookup store for datapath blocks that need indexed, multi-dimensional value access.
// PARAMETERS
//  DIM   3  number of rows (>=2)
//  COLS  7  number of columns (>=2)
//  W     4  bits per cell value
//  RW = $clog2(DIM), CW = $clog2(COLS), SW = W+$clog2(COLS+1) (localparams)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-low reset
//  clr        in   1        synchronous clear of whole matrix and bitmap
//  wr_en      in   1        write strobe
//  wr_row     in   RW       write row index
//  wr_col     in   CW       write column index
//  wr_data    in   W        write value
//  rd_en      in   1        row-read strobe
//  rd_row     in   RW       read row index
//  rd_data    out  [COLS]xW unpacked array: registered row values
//  rd_valid   out  [COLS]x1 unpacked array: registered row valid bits
//  row_sum    out  SW       registered sum of valid cells of read row
//  rd_ack     out  1        pulses 1 cycle after accepted rd_en
//  valid_map  out  [DIM][COLS]x1 live valid bitmap
//  any_valid  out  1        OR of valid_map
//  addr_err   out  1        pulses 1 cycle after an out-of-range wr/rd index
// BEHAVIOUR
//  - rst low (async): all cells 0, valid_map 0, rd_data 0, rd_valid 0, row_sum 0, rd_ack 0, addr_err 0.
//  - Write: wr_en & wr_row<DIM & wr_col<COLS -> cell<=wr_data, valid<=1 at next edge; visible next cycle.
//  - Read: rd_en & rd_row<DIM -> next edge rd_data/rd_valid/row_sum load row, rd_ack=1 for one cycle.
//  - Read latency 1 cycle; outputs hold last read until next accepted read, clr or reset.
//  - Same-cycle write and read of same row: read returns pre-write contents (no bypass).
//  - row_sum: unsigned sum of cells whose valid=1; invalid cells contribute 0; width SW never overflows.
//  - Out-of-range index (row>=DIM or col>=COLS) with strobe: no state change, addr_err=1 next cycle.
//  - clr: all cells and valid_map to 0, rd_* outputs to 0; clr wins over simultaneous wr_en/rd_en.
//  - any_valid combinational from valid_map; valid bits only cleared by clr/reset.
//  - Unused indices when DIM/COLS not power of two are treated as out-of-range.
// CONFIGURATION
//  VAL_MATRIX_ACC_EN defined: adds input wr_acc (1). wr_en & wr_acc -> cell<=sat(cell+wr_data)
//   saturating at 2^W-1, valid<=1; wr_acc=0 behaves as plain write.
//  Not defined: no wr_acc port; every write overwrites the cell.
// TESTING
//  1 Reset: rst=0 mid-traffic -> all outputs 0 immediately; any_valid=0.
//  2 Write (1,2)=5,(1,6)=9; read row1 -> next cycle rd_data[2]=5,[6]=9, row_sum=14, rd_ack=1.
//  3 Write row2 all COLS cells =15 (W=4) -> row_sum=105, any_valid=1; clr -> row_sum 0, valid_map 0.
//  4 wr_row=3 (DIM=3) wr_en -> addr_err pulses 1 cycle, matrix unchanged.
//  5 Same-cycle write (0,0)=7 and read row0 -> rd_data[0]=0; reread next cycle -> 7.
//  6 ACC_EN: cell 12, acc write 9 -> 15 (saturated); acc write 1 on empty cell -> 1.

Source files
------------

// File: rtl/val_matrix.sv
// Purpose: DIM x COLS matrix of W-bit cells with a per-cell valid bitmap, one cell write and one registered row read per cycle.
// Latency: writes become visible the next cycle; a row read appears one cycle after the accepted rd_en.
// Backpressure: none, every in-range strobe is taken at once. Define VAL_MATRIX_ACC_EN to add saturating accumulate writes (wr_acc).
module val_matrix #(
    parameter int DIM  = 3,
    parameter int COLS = 7,
    parameter int W    = 4,
    localparam int RW  = $clog2(DIM),
    localparam int CW  = $clog2(COLS),
    localparam int SW  = W + $clog2(COLS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
`ifdef VAL_MATRIX_ACC_EN
    input  logic          wr_acc,
`endif
    input  logic [RW-1:0] wr_row,
    input  logic [CW-1:0] wr_col,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [RW-1:0] rd_row,
    output logic [W-1:0]  rd_data [COLS],
    output logic          rd_valid [COLS],
    output logic [SW-1:0] row_sum,
    output logic          rd_ack,
    output logic          valid_map [DIM][COLS],
    output logic          any_valid,
    output logic          addr_err
);

    logic [W-1:0]  cells [DIM][COLS];
    logic          wr_in;
    logic          rd_in;
    logic          wr_ok;
    logic          rd_ok;
    logic [RW-1:0] wr_r;
    logic [CW-1:0] wr_c;
    logic [RW-1:0] rd_r;
    logic [W-1:0]  wr_next;
    logic [SW-1:0] sum_next;

    // Non-power-of-two sizes leave index codes that must be rejected.
    assign wr_in = ({1'b0, wr_row} < (RW+1)'(DIM)) && ({1'b0, wr_col} < (CW+1)'(COLS));
    assign rd_in = ({1'b0, rd_row} < (RW+1)'(DIM));
    assign wr_ok = wr_en && wr_in;
    assign rd_ok = rd_en && rd_in;

    // Clamped indices keep combinational lookups inside the array.
    assign wr_r = wr_in ? wr_row : '0;
    assign wr_c = wr_in ? wr_col : '0;
    assign rd_r = rd_in ? rd_row : '0;

`ifdef VAL_MATRIX_ACC_EN
    logic [W:0] acc_sum;

    always_comb begin
        acc_sum = {1'b0, cells[wr_r][wr_c]} + {1'b0, wr_data};
        wr_next = wr_data;
        if (wr_acc) begin
            wr_next = acc_sum[W] ? {W{1'b1}} : acc_sum[W-1:0];
        end
    end
`else
    assign wr_next = wr_data;
`endif

    // Sum uses the pre-write row, so a same-cycle write is not bypassed.
    always_comb begin
        sum_next = '0;
        for (int c = 0; c < COLS; c++) begin
            if (valid_map[rd_r][c]) begin
                sum_next = sum_next + SW'(cells[rd_r][c]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    cells[r][c]     <= '0;
                    valid_map[r][c] <= 1'b0;
                end
            end
        end else if (clr) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    cells[r][c]     <= '0;
                    valid_map[r][c] <= 1'b0;
                end
            end
        end else if (wr_ok) begin
            cells[wr_r][wr_c]     <= wr_next;
            valid_map[wr_r][wr_c] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < COLS; c++) begin
                rd_data[c]  <= '0;
                rd_valid[c] <= 1'b0;
            end
            row_sum <= '0;
            rd_ack  <= 1'b0;
        end else if (clr) begin
            for (int c = 0; c < COLS; c++) begin
                rd_data[c]  <= '0;
                rd_valid[c] <= 1'b0;
            end
            row_sum <= '0;
            rd_ack  <= 1'b0;
        end else begin
            rd_ack <= rd_ok;
            if (rd_ok) begin
                for (int c = 0; c < COLS; c++) begin
                    rd_data[c]  <= cells[rd_r][c];
                    rd_valid[c] <= valid_map[rd_r][c];
                end
                row_sum <= sum_next;
            end
        end
    end

    // Error flag reports the rejected request even when clr is also high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= (wr_en && !wr_in) || (rd_en && !rd_in);
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < COLS; c++) begin
                any_valid = any_valid | valid_map[r][c];
            end
        end
    end

endmodule

// File: tb/tb_val_matrix.sv
// Directed bench for val_matrix: write/read, row sums, clr, range errors, read-before-write and async reset.
module tb_val_matrix;

    localparam int DIM  = 3;
    localparam int COLS = 7;
    localparam int W    = 4;
    localparam int RW   = 2;
    localparam int CW   = 3;
    localparam int SW   = 7;

    logic          clk;
    logic          rst;
    logic          clr;
    logic          wr_en;
    logic          wr_acc;
    logic [RW-1:0] wr_row;
    logic [CW-1:0] wr_col;
    logic [W-1:0]  wr_data;
    logic          rd_en;
    logic [RW-1:0] rd_row;
    logic [W-1:0]  rd_data [COLS];
    logic          rd_valid [COLS];
    logic [SW-1:0] row_sum;
    logic          rd_ack;
    logic          valid_map [DIM][COLS];
    logic          any_valid;
    logic          addr_err;

    int total;
    int passed;

    val_matrix dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .wr_en     (wr_en),
`ifdef VAL_MATRIX_ACC_EN
        .wr_acc    (wr_acc),
`endif
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_row    (rd_row),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .row_sum   (row_sum),
        .rd_ack    (rd_ack),
        .valid_map (valid_map),
        .any_valid (any_valid),
        .addr_err  (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 1'b0; wr_en = 1'b0; wr_acc = 1'b0; rd_en = 1'b0;
        wr_row = '0; wr_col = '0; wr_data = '0; rd_row = '0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        idle();
        rst = 1'b0;
        #12;
        chk("reset_rd_ack", 32'(rd_ack), 0);
        chk("reset_row_sum", 32'(row_sum), 0);
        chk("reset_any_valid", 32'(any_valid), 0);
        chk("reset_addr_err", 32'(addr_err), 0);
        rst = 1'b1;
        step();

        // Two writes into row 1, then read it back.
        wr_en = 1'b1; wr_row = 2'd1; wr_col = 3'd2; wr_data = 4'd5;
        step();
        wr_col = 3'd6; wr_data = 4'd9;
        step();
        idle();
        rd_en = 1'b1; rd_row = 2'd1;
        step();
        idle();
        chk("r1_data2", 32'(rd_data[2]), 5);
        chk("r1_data6", 32'(rd_data[6]), 9);
        chk("r1_valid2", 32'(rd_valid[2]), 1);
        chk("r1_valid0", 32'(rd_valid[0]), 0);
        chk("r1_sum", 32'(row_sum), 14);
        chk("r1_ack", 32'(rd_ack), 1);
        chk("map_1_6", 32'(valid_map[1][6]), 1);
        chk("any_valid_set", 32'(any_valid), 1);
        step();
        chk("ack_one_cycle", 32'(rd_ack), 0);
        chk("sum_holds", 32'(row_sum), 14);

        // Out-of-range row and column writes are dropped and flagged.
        wr_en = 1'b1; wr_row = 2'd3; wr_col = 3'd0; wr_data = 4'd15;
        step();
        idle();
        chk("oor_row_err", 32'(addr_err), 1);
        wr_en = 1'b1; wr_row = 2'd0; wr_col = 3'd7; wr_data = 4'd15;
        step();
        idle();
        chk("oor_col_err", 32'(addr_err), 1);
        rd_en = 1'b1; rd_row = 2'd0;
        step();
        idle();
        chk("err_pulse_end", 32'(addr_err), 0);
        chk("row0_untouched", 32'(row_sum), 0);
        chk("map_0_6_clear", 32'(valid_map[0][6]), 0);
        rd_en = 1'b1; rd_row = 2'd3;
        step();
        idle();
        chk("oor_rd_err", 32'(addr_err), 1);
        chk("oor_rd_no_ack", 32'(rd_ack), 0);
        chk("oor_rd_hold", 32'(row_sum), 0);

        // Fill row 2 with the maximum value.
        for (int c = 0; c < COLS; c++) begin
            wr_en = 1'b1; wr_row = 2'd2; wr_col = 3'(c); wr_data = 4'd15;
            step();
        end
        idle();
        rd_en = 1'b1; rd_row = 2'd2;
        step();
        idle();
        chk("r2_full_sum", 32'(row_sum), 105);
        chk("r2_data4", 32'(rd_data[4]), 15);

        // clr wins over a simultaneous write.
        clr = 1'b1; wr_en = 1'b1; wr_row = 2'd0; wr_col = 3'd1; wr_data = 4'd3;
        step();
        idle();
        chk("clr_row_sum", 32'(row_sum), 0);
        chk("clr_rd_data", 32'(rd_data[4]), 0);
        chk("clr_map_1_2", 32'(valid_map[1][2]), 0);
        chk("clr_map_0_1", 32'(valid_map[0][1]), 0);
        chk("clr_any_valid", 32'(any_valid), 0);

        // Same-cycle write and read of row 0 returns the old contents.
        wr_en = 1'b1; wr_row = 2'd0; wr_col = 3'd0; wr_data = 4'd7;
        rd_en = 1'b1; rd_row = 2'd0;
        step();
        idle();
        chk("rbw_old_data", 32'(rd_data[0]), 0);
        chk("rbw_old_valid", 32'(rd_valid[0]), 0);
        chk("rbw_ack", 32'(rd_ack), 1);
        rd_en = 1'b1; rd_row = 2'd0;
        step();
        idle();
        chk("reread_data", 32'(rd_data[0]), 7);
        chk("reread_sum", 32'(row_sum), 7);

        // Second write to (0,3): accumulate in the ACC build, overwrite otherwise.
        wr_en = 1'b1; wr_row = 2'd0; wr_col = 3'd3; wr_data = 4'd12;
        step();
        wr_acc = 1'b1; wr_data = 4'd9;
        step();
        wr_col = 3'd4; wr_data = 4'd1;
        step();
        idle();
        rd_en = 1'b1; rd_row = 2'd0;
        step();
        idle();
`ifdef VAL_MATRIX_ACC_EN
        chk("acc_saturate", 32'(rd_data[3]), 15);
        chk("acc_empty", 32'(rd_data[4]), 1);
        chk("acc_sum", 32'(row_sum), 23);
`else
        chk("overwrite", 32'(rd_data[3]), 9);
        chk("plain_write", 32'(rd_data[4]), 1);
        chk("overwrite_sum", 32'(row_sum), 17);
`endif

        // Asynchronous reset in the middle of traffic.
        wr_en = 1'b1; wr_row = 2'd1; wr_col = 3'd1; wr_data = 4'd4;
        rd_en = 1'b1; rd_row = 2'd0;
        #3;
        rst = 1'b0;
        #1;
        chk("arst_row_sum", 32'(row_sum), 0);
        chk("arst_rd_data", 32'(rd_data[0]), 0);
        chk("arst_rd_ack", 32'(rd_ack), 0);
        chk("arst_any_valid", 32'(any_valid), 0);
        chk("arst_map", 32'(valid_map[0][0]), 0);
        idle();
        step();
        rst = 1'b1;
        rd_en = 1'b1; rd_row = 2'd0;
        step();
        idle();
        chk("post_arst_sum", 32'(row_sum), 0);
        chk("post_arst_ack", 32'(rd_ack), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
